// File: rtl/aes_pkg.sv
// Shared AES-128 constants and byte-level helpers for the iterative encryption core.
// State bytes are column-major: byte i lives at bits [127-8i -: 8], row i%4, column i/4.
package aes_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } fsm_t;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Indexed directly by the round counter; entries past round 10 are never used.
    localparam logic [7:0] RCON [16] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8*(r + 4*c) -: 8] = s[127 - 8*(r + 4*((c + r) % 4)) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c -: 8];
            a1 = s[119 - 32*c -: 8];
            a2 = s[111 - 32*c -: 8];
            a3 = s[103 - 32*c -: 8];
            o[127 - 32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[119 - 32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[111 - 32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[103 - 32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box lookup for one byte.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] din,
    output logic [7:0] dout
);

    assign dout = SBOX[din];

endmodule

// File: rtl/encryption.sv
// Iterative AES-128 encryption: one round per clock with the round key expanded on the fly.
module encryption
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         reset_n,
    input  logic [127:0] plain_text,
    input  logic [127:0] key_in,
    input  logic         set_new_key,
    input  logic         start,
    input  logic         restart,
    output logic [127:0] cipher_text
);

    fsm_t         fsm_q, fsm_d;
    logic [3:0]   rnd_q, rnd_d;
    logic [127:0] state_q, state_d;
    logic [127:0] rkey_q, rkey_d;
    logic [127:0] ct_q, ct_d;
    logic [127:0] key_q, key_d;

    logic [127:0] sub_bytes;
    logic [127:0] shifted;
    logic [127:0] round_out;
    logic [31:0]  rot_w3;
    logic [31:0]  sub_word;
    logic [31:0]  temp;
    logic [127:0] nk;

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_state_sbox
            aes_sbox u_sbox (
                .din  (state_q[127 - 8*gi -: 8]),
                .dout (sub_bytes[127 - 8*gi -: 8])
            );
        end
        for (gi = 0; gi < 4; gi++) begin : g_key_sbox
            aes_sbox u_sbox (
                .din  (rot_w3[31 - 8*gi -: 8]),
                .dout (sub_word[31 - 8*gi -: 8])
            );
        end
    endgenerate

    // Key-schedule step: w[i] = w[i-4] ^ w[i-1], with SubWord(RotWord) on the first word.
    assign rot_w3       = {rkey_q[23:0], rkey_q[31:24]};
    assign temp         = sub_word ^ {RCON[rnd_q], 24'h000000};
    assign nk[127:96]   = rkey_q[127:96] ^ temp;
    assign nk[95:64]    = rkey_q[95:64]  ^ nk[127:96];
    assign nk[63:32]    = rkey_q[63:32]  ^ nk[95:64];
    assign nk[31:0]     = rkey_q[31:0]   ^ nk[63:32];

    assign shifted   = shift_rows(sub_bytes);
    assign round_out = ((rnd_q == 4'd10) ? shifted : mix_columns(shifted)) ^ nk;

    always_comb begin
        key_d = set_new_key ? key_in : key_q;
    end

    // Deliberately outside reset so a key loaded before reset survives it.
    always_ff @(posedge clk) begin
        key_q <= key_d;
    end

    always_comb begin
        fsm_d   = fsm_q;
        rnd_d   = rnd_q;
        state_d = state_q;
        rkey_d  = rkey_q;
        ct_d    = ct_q;
        if (restart) begin
            fsm_d = ST_IDLE;
            rnd_d = 4'd0;
        end else begin
            case (fsm_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d = plain_text ^ key_q;
                        rkey_d  = key_q;
                        rnd_d   = 4'd1;
                        fsm_d   = ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    state_d = round_out;
                    rkey_d  = nk;
                    if (rnd_q == 4'd10) begin
                        ct_d  = round_out;
                        rnd_d = 4'd0;
                        fsm_d = ST_IDLE;
                    end else begin
                        rnd_d = rnd_q + 4'd1;
                    end
                end
                default: begin
                    fsm_d = ST_IDLE;
                    rnd_d = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fsm_q   <= ST_IDLE;
            rnd_q   <= 4'd0;
            state_q <= '0;
            rkey_q  <= '0;
            ct_q    <= '0;
        end else begin
            fsm_q   <= fsm_d;
            rnd_q   <= rnd_d;
            state_q <= state_d;
            rkey_q  <= rkey_d;
            ct_q    <= ct_d;
        end
    end

    assign cipher_text = ct_q;

endmodule

// File: tb/tb_encryption.sv
// Directed bench for the AES-128 core using the FIPS-197 App. B and App. C.1 vectors.
module tb_encryption;

    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk;
    logic         reset_n;
    logic [127:0] plain_text;
    logic [127:0] key_in;
    logic         set_new_key;
    logic         start;
    logic         restart;
    logic [127:0] cipher_text;

    int tests_run    = 0;
    int tests_failed = 0;

    encryption dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .plain_text  (plain_text),
        .key_in      (key_in),
        .set_new_key (set_new_key),
        .start       (start),
        .restart     (restart),
        .cipher_text (cipher_text)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %032h expected %032h", tag, got, exp);
        end else begin
            $display("ok   %s: %032h", tag, got);
        end
    endtask

    task automatic load_key(input logic [127:0] k);
        key_in      = k;
        set_new_key = 1'b1;
        tick();
        set_new_key = 1'b0;
    endtask

    // Pulses start at edge E0 and leaves the bench just after E0.
    task automatic kick(input logic [127:0] pt);
        plain_text = pt;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    initial begin
        reset_n     = 1'b0;
        plain_text  = '0;
        key_in      = '0;
        set_new_key = 1'b0;
        start       = 1'b0;
        restart     = 1'b0;
        ticks(2);
        reset_n = 1'b1;
        tick();

        // App. B: key loaded before a reset pulse must survive it.
        load_key(KEY_B);
        reset_n = 1'b0;
        #1;
        check_val("rst_ct", cipher_text, 128'h0);
        ticks(2);
        reset_n = 1'b1;
        tick();
        kick(PT_B);
        ticks(9);
        check_val("b_e9", cipher_text, 128'h0);
        tick();
        check_val("app_b", cipher_text, CT_B);

        // App. C.1 with exact latency; plain_text changed after E0 must not matter.
        load_key(KEY_C);
        kick(PT_C);
        plain_text = 128'hdeadbeef_00000000_cafef00d_12345678;
        ticks(9);
        check_val("c_e9", cipher_text, CT_B);
        tick();
        check_val("app_c", cipher_text, CT_C);

        // Asynchronous reset mid-round clears the output without a clock edge.
        load_key(KEY_B);
        kick(PT_B);
        ticks(4);
        reset_n = 1'b0;
        #1;
        check_val("rst_async", cipher_text, 128'h0);
        tick();
        reset_n = 1'b1;
        ticks(12);
        check_val("rst_idle", cipher_text, 128'h0);
        kick(PT_B);
        ticks(10);
        check_val("rst_b", cipher_text, CT_B);

        // Restart during round 5 leaves the previous result in place.
        load_key(KEY_C);
        kick(PT_C);
        ticks(4);
        restart = 1'b1;
        tick();
        restart = 1'b0;
        ticks(10);
        check_val("restart_hold", cipher_text, CT_B);
        kick(PT_C);
        ticks(10);
        check_val("restart_c", cipher_text, CT_C);

        // Restart wins over start in the same cycle.
        load_key(KEY_B);
        plain_text = PT_B;
        start      = 1'b1;
        restart    = 1'b1;
        tick();
        start      = 1'b0;
        restart    = 1'b0;
        ticks(11);
        check_val("restart_prio", cipher_text, CT_C);

        // start and set_new_key while busy in round 3: running block is unaffected.
        kick(PT_B);
        ticks(2);
        plain_text  = PT_C;
        key_in      = KEY_C;
        set_new_key = 1'b1;
        start       = 1'b1;
        tick();
        set_new_key = 1'b0;
        start       = 1'b0;
        ticks(6);
        check_val("busy_e9", cipher_text, CT_C);
        tick();
        check_val("busy_b", cipher_text, CT_B);
        kick(PT_C);
        ticks(10);
        check_val("busy_next", cipher_text, CT_C);

        // set_new_key with start in one cycle: old key used now, new key next time.
        load_key(KEY_B);
        plain_text  = PT_B;
        key_in      = KEY_C;
        set_new_key = 1'b1;
        start       = 1'b1;
        tick();
        set_new_key = 1'b0;
        start       = 1'b0;
        ticks(10);
        check_val("same_cycle", cipher_text, CT_B);

        // Back-to-back: start accepted at E0+11, the first edge back in IDLE.
        kick(PT_C);
        plain_text = '0;
        ticks(10);
        check_val("b2b", cipher_text, CT_C);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
